// File: rtl/sweep_pkg.sv
// Shared definitions for the exhaustive-stimulus sweeper.
//   - sweep_state_e : FSM state encodings
//   - DEFAULT_POLY  : default MISR feedback polynomial (8-bit)
//   - bin2gray      : binary to reflected-Gray conversion
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweep_state_e;

  localparam logic [7:0] DEFAULT_POLY = 8'h1D;

  function automatic logic [15:0] bin2gray(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/sweep_stim_gen_if.sv
// Bundle between the control/bench side and the sweeper.
//   master : drives start/abort/pause/gray_mode and the DUT response resp
//   slave  : the sweeper; drives stim/sample/busy/done/signature/pat_idx
interface sweep_stim_gen_if #(
  parameter int WIDTH  = 4,
  parameter int RESP_W = 2,
  parameter int SIG_W  = 8
);
  logic              start;
  logic              abort;
  logic              pause;
  logic              gray_mode;
  logic [RESP_W-1:0] resp;
  logic [WIDTH-1:0]  stim;
  logic              sample;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  signature;
  logic [WIDTH-1:0]  pat_idx;

  modport master (
    output start, abort, pause, gray_mode, resp,
    input  stim, sample, busy, done, signature, pat_idx
  );

  modport slave (
    input  start, abort, pause, gray_mode, resp,
    output stim, sample, busy, done, signature, pat_idx
  );
endinterface

// File: rtl/sweep_misr.sv
// Multiple-input signature register.
//   clk, rst_n : clock, async active-low reset (sig -> 0)
//   clr        : synchronous clear, wins over en
//   en         : fold din into the signature this edge
//   din        : RESP_W-bit input, zero-extended to SIG_W
//   sig        : current signature
module sweep_misr #(
  parameter int                SIG_W  = 8,
  parameter logic [SIG_W-1:0]  POLY   = 8'h1D,
  parameter int                RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RESP_W-1:0] din,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] din_ext;

  always_comb begin
    din_ext              = '0;
    din_ext[RESP_W-1:0]  = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= (sig << 1) ^ (sig[SIG_W-1] ? POLY : '0) ^ din_ext;
    end
  end

endmodule

// File: rtl/sweep_stim_gen.sv
// Exhaustive stimulus sweeper: walks all 2^WIDTH patterns (binary or Gray
// order), holds each for HOLD cycles, and folds the response sampled on the
// last hold cycle into a MISR signature.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of sweep_stim_gen_if (control, stim/resp, status)
//
// state | meaning
// IDLE  | waiting for start; outputs cleared
// DRIVE | sweep running, stim driven, hold counter active
// DONE  | sweep complete, done held, stim keeps the last pattern
module sweep_stim_gen
  import sweep_pkg::*;
#(
  parameter int               WIDTH  = 4,
  parameter int               RESP_W = 2,
  parameter int               HOLD   = 5,
  parameter int               SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEFAULT_POLY)
) (
  input logic               clk,
  input logic               rst_n,
  sweep_stim_gen_if.slave   bus
);

  localparam int              HCW       = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HCW-1:0]  HOLD_LAST = HCW'(HOLD - 1);
  localparam logic [WIDTH-1:0] IDX_LAST = '1;

  sweep_state_e     state_q, state_d;
  logic [WIDTH-1:0] stim_q, stim_d;
  logic [WIDTH-1:0] idx_q, idx_d, idx_inc;
  logic [HCW-1:0]   hold_q, hold_d;
  logic             gray_q, gray_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             capture;
  logic             misr_clr, misr_en;
  logic [SIG_W-1:0] sig;

  assign idx_inc = idx_q + WIDTH'(1);
  assign capture = (state_q == DRIVE) && !bus.pause && (hold_q == HOLD_LAST);

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    gray_d   = gray_q;
    busy_d   = busy_q;
    done_d   = done_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;

    if (bus.abort) begin
      // signature is deliberately left alone so it can be inspected after abort
      state_d = IDLE;
      stim_d  = '0;
      idx_d   = '0;
      hold_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_d  = DRIVE;
            gray_d   = bus.gray_mode;
            stim_d   = '0;
            idx_d    = '0;
            hold_d   = '0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            misr_clr = 1'b1;
          end
        end
        DRIVE: begin
          if (!bus.pause) begin
            if (hold_q != HOLD_LAST) begin
              hold_d = hold_q + HCW'(1);
            end else begin
              misr_en = 1'b1;
              if (idx_q == IDX_LAST) begin
                state_d = DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                idx_d  = idx_inc;
                stim_d = gray_q ? WIDTH'(bin2gray(16'(idx_inc))) : idx_inc;
                hold_d = '0;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stim_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      gray_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      gray_q  <= gray_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sweep_misr #(
    .SIG_W  (SIG_W),
    .POLY   (POLY),
    .RESP_W (RESP_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (misr_clr),
    .en    (misr_en),
    .din   (bus.resp),
    .sig   (sig)
  );

  // an aborted capture cycle is not a capture, so no pulse either
  assign bus.sample    = capture && !bus.abort;
  assign bus.stim      = stim_q;
  assign bus.pat_idx   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.signature = sig;

endmodule

// File: tb/tb_sweep_stim_gen.sv
module tb_sweep_stim_gen;

  typedef struct {
    logic [3:0] stim;
    logic [3:0] idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sweep_stim_gen_if #(.WIDTH(4), .RESP_W(2), .SIG_W(8)) ia ();
  sweep_stim_gen_if #(.WIDTH(2), .RESP_W(2), .SIG_W(8)) ib ();

  sweep_stim_gen #(.WIDTH(4), .RESP_W(2), .HOLD(5), .SIG_W(8), .POLY(8'h1D)) u_a (
    .clk (clk), .rst_n (rst_n), .bus (ia.slave)
  );
  sweep_stim_gen #(.WIDTH(2), .RESP_W(2), .HOLD(1), .SIG_W(8), .POLY(8'h1D)) u_b (
    .clk (clk), .rst_n (rst_n), .bus (ib.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t qa[$];
  logic [1:0] qb[$];

  function automatic logic [1:0] resp_fn(input logic [3:0] s);
    return {s[3] ^ s[1], s[2] | s[0]};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [1:0] r);
    return {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {6'b0, r};
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endfunction

  assign ia.resp = resp_fn(ia.stim);
  assign ib.resp = 2'b01;

  // scoreboard monitors: every sample pulse must match the next queued pattern
  always @(negedge clk) begin
    if (rst_n && ia.sample) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_sample: stim=%0d with empty queue at %0t", ia.stim, $time);
      end else begin
        exp_t e;
        e = qa.pop_front();
        chk("a_stim", int'(ia.stim), int'(e.stim));
        chk("a_idx", int'(ia.pat_idx), int'(e.idx));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && ib.sample) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_sample: stim=%0d with empty queue at %0t", ib.stim, $time);
      end else begin
        logic [1:0] e;
        e = qb.pop_front();
        chk("b_stim", int'(ib.stim), int'(e));
      end
    end
  end

  logic [3:0] gray_tab [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

  // issue a start to DUT A, queue the expected patterns and return the model signature
  task automatic start_a(input bit gray, output logic [7:0] exp_sig);
    logic [7:0] s;
    s = 8'h00;
    @(negedge clk);
    ia.gray_mode = gray;
    ia.start     = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_t e;
      e.idx  = 4'(i);
      e.stim = gray ? gray_tab[i] : 4'(i);
      qa.push_back(e);
      s = misr_step(s, resp_fn(e.stim));
    end
    exp_sig = s;
    @(posedge clk);
    #1;
    ia.start     = 1'b0;
    ia.gray_mode = ~gray;
    chk("a_start_sig_clr", int'(ia.signature), 0);
    chk("a_start_busy", int'(ia.busy), 1);
  endtask

  task automatic sweep_a(input string tag, input bit gray, input bit do_pause,
                         input bit poke_start, input int exp_cyc);
    logic [7:0] exp_sig;
    int  cyc;
    bit  fin;
    cyc = 0;
    fin = 1'b0;
    start_a(gray, exp_sig);
    while (!fin && cyc < 300) begin
      @(posedge clk);
      cyc++;
      #1;
      if (do_pause) begin
        ia.pause = (cyc >= 17 && cyc < 24);
        if (cyc == 20) begin
          chk({tag, "_pause_stim"}, int'(ia.stim), 3);
          chk({tag, "_pause_sample"}, int'(ia.sample), 0);
        end
      end
      if (poke_start) ia.start = (cyc == 30 || cyc == 50);
      if (ia.done) fin = 1'b1;
    end
    ia.pause = 1'b0;
    ia.start = 1'b0;
    chk({tag, "_done_cycle"}, cyc, exp_cyc);
    chk({tag, "_busy"}, int'(ia.busy), 0);
    chk({tag, "_done"}, int'(ia.done), 1);
    chk({tag, "_last_stim"}, int'(ia.stim), gray ? 8 : 15);
    chk({tag, "_signature"}, int'(ia.signature), int'(exp_sig));
    chk({tag, "_samples_left"}, qa.size(), 0);
  endtask

  initial begin
    logic [7:0] exp_sig;
    logic [7:0] part_sig;
    logic [7:0] b_sig [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
    int   cyc;

    ia.start = 1'b0; ia.abort = 1'b0; ia.pause = 1'b0; ia.gray_mode = 1'b0;
    ib.start = 1'b0; ib.abort = 1'b0; ib.pause = 1'b0; ib.gray_mode = 1'b0;

    #22;
    chk("rst_stim", int'(ia.stim), 0);
    chk("rst_busy", int'(ia.busy), 0);
    chk("rst_done", int'(ia.done), 0);
    chk("rst_sig", int'(ia.signature), 0);
    chk("rst_idx", int'(ia.pat_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    sweep_a("bin", 1'b0, 1'b0, 1'b0, 80);
    sweep_a("gray", 1'b1, 1'b0, 1'b0, 80);
    sweep_a("pause", 1'b0, 1'b1, 1'b0, 87);

    // abort at pattern 9: patterns 0..8 already folded into the signature
    start_a(1'b0, exp_sig);
    part_sig = 8'h00;
    for (int i = 0; i < 9; i++) part_sig = misr_step(part_sig, resp_fn(4'(i)));
    cyc = 0;
    while (ia.pat_idx != 4'd9 && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    chk("abort_reach_idx9", int'(ia.pat_idx), 9);
    ia.abort = 1'b1;
    @(posedge clk);
    #1;
    ia.abort = 1'b0;
    chk("abort_stim", int'(ia.stim), 0);
    chk("abort_idx", int'(ia.pat_idx), 0);
    chk("abort_busy", int'(ia.busy), 0);
    chk("abort_done", int'(ia.done), 0);
    chk("abort_sig", int'(ia.signature), int'(part_sig));
    qa.delete();
    sweep_a("restart", 1'b0, 1'b0, 1'b0, 80);

    // asynchronous reset between edges
    start_a(1'b0, exp_sig);
    repeat (23) @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stim", int'(ia.stim), 0);
    chk("arst_busy", int'(ia.busy), 0);
    chk("arst_sig", int'(ia.signature), 0);
    chk("arst_idx", int'(ia.pat_idx), 0);
    chk("arst_sample", int'(ia.sample), 0);
    @(negedge clk);
    rst_n = 1'b1;
    qa.delete();
    sweep_a("startpoke", 1'b0, 1'b0, 1'b1, 80);

    // WIDTH=2 HOLD=1 instance, resp tied to 01
    @(negedge clk);
    ib.start = 1'b1;
    for (int i = 0; i < 4; i++) qb.push_back(2'(i));
    @(posedge clk);
    #1;
    ib.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b_sig_%0d", c), int'(ib.signature), int'(b_sig[c-1]));
      chk($sformatf("b_done_%0d", c), int'(ib.done), (c == 4) ? 1 : 0);
    end
    chk("b_samples_left", qb.size(), 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
